exec_sequencer: RTL and testbench

//  Execute-stage controller for the PDP8 core; sits between the IFD and the shared memory port.

---
 rtl/exec_sequencer_if.sv | 61 ++++++
 rtl/exec_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_exec_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// IFD and shared-memory-port signals of the PDP8 execute-stage sequencer.
// master = sequencer side, slave = IFD / memory arbiter side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

interface exec_sequencer_if;
  typedef struct packed {
    logic AND;
    logic TAD;
    logic ISZ;
    logic DCA;
    logic JMS;
    logic JMP;
    logic [`ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CLA_CLL;
    logic CLA1;
    logic CLA2;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
  } pdp_op7_opcode_s;

  pdp_mem_opcode_s          pdp_mem_opcode;
  pdp_op7_opcode_s          pdp_op7_opcode;
  logic                     stall;
  logic [`ADDR_WIDTH-1:0]   PC_value;
  logic                     exec_rd_req;
  logic                     exec_wr_req;
  logic [`ADDR_WIDTH-1:0]   exec_addr;
  logic [11:0]              exec_wdata;
  logic                     exec_mem_gnt;
  logic [11:0]              exec_rdata;

  modport master (
    input  pdp_mem_opcode, pdp_op7_opcode, exec_mem_gnt, exec_rdata,
    output stall, PC_value, exec_rd_req, exec_wr_req, exec_addr, exec_wdata
  );

  modport slave (
    output pdp_mem_opcode, pdp_op7_opcode, exec_mem_gnt, exec_rdata,
    input  stall, PC_value, exec_rd_req, exec_wr_req, exec_addr, exec_wdata
  );
endinterface

// File: rtl/exec_sequencer.sv
// PDP8 execute-stage controller: sequences memory-reference operand traffic,
// updates AC/LINK and hands the next PC back to the IFD.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module exec_sequencer #(
  parameter logic [`ADDR_WIDTH-1:0] START_PC   = 12'o0200,
  parameter int                     DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  exec_sequencer_if.master      bus,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  link,
  output logic                  illegal_op
);
  localparam int AW = `ADDR_WIDTH;
  localparam logic [AW-1:0]         ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]         TWO_A = {{(AW-2){1'b0}}, 2'b10};
  localparam logic [DATA_WIDTH-1:0] ONE_D = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO_D = {DATA_WIDTH{1'b0}};

  // op_r bit positions, same order as the opcode struct
  localparam int OP_AND = 5;
  localparam int OP_TAD = 4;
  localparam int OP_DCA = 2;

  typedef enum logic [2:0] {
    S_CLR  = 3'd0,
    S_IDLE = 3'd1,
    S_RD   = 3'd2,
    S_RDW  = 3'd3,
    S_EXE  = 3'd4,
    S_WR   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                  state_r;
  logic                    stall_r;
  logic [AW-1:0]           pc_r;
  logic [DATA_WIDTH-1:0]   ac_r;
  logic                    link_r;
  logic [DATA_WIDTH-1:0]   md_r;
  logic [AW-1:0]           ea_r;
  logic [5:0]              op_r;
  logic                    rd_req_r;
  logic                    wr_req_r;
  logic [AW-1:0]           addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    illegal_r;

  logic [5:0]              mem_bits_s;
  logic                    mem_any_s;
  logic                    op7_any_s;
  logic                    opcode_any_s;
  logic                    illegal_s;
  logic [DATA_WIDTH:0]     sum_s;

  function automatic logic multi_hot(input logic [5:0] v);
    return (v & (v - 6'd1)) != 6'd0;
  endfunction

  assign mem_bits_s   = {bus.pdp_mem_opcode.AND, bus.pdp_mem_opcode.TAD,
                         bus.pdp_mem_opcode.ISZ, bus.pdp_mem_opcode.DCA,
                         bus.pdp_mem_opcode.JMS, bus.pdp_mem_opcode.JMP};
  assign mem_any_s    = |mem_bits_s;
  assign op7_any_s    = |bus.pdp_op7_opcode;
  assign opcode_any_s = mem_any_s | op7_any_s;
  assign illegal_s    = multi_hot(mem_bits_s) | (mem_any_s & op7_any_s);
  assign sum_s        = {1'b0, ac_r} + {1'b0, md_r};

  // Sequencer FSM; every output is a register written here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_CLR;
      stall_r   <= 1'b0;
      pc_r      <= START_PC;
      ac_r      <= ZERO_D;
      link_r    <= 1'b0;
      md_r      <= ZERO_D;
      ea_r      <= {AW{1'b0}};
      op_r      <= 6'b000000;
      rd_req_r  <= 1'b0;
      wr_req_r  <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= ZERO_D;
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= 1'b0;
      case (state_r)
        // Waiting for the IFD to drop its opcode keeps a held one from running twice
        S_CLR: begin
          if (!opcode_any_s) state_r <= S_IDLE;
        end
        S_IDLE: begin
          if (opcode_any_s) begin
            ea_r <= bus.pdp_mem_opcode.mem_inst_addr;
            op_r <= mem_bits_s;
            if (illegal_s) begin
              illegal_r <= 1'b1;
              pc_r      <= pc_r + ONE_A;
              state_r   <= S_DONE;
            end else if (bus.pdp_mem_opcode.JMP) begin
              pc_r    <= bus.pdp_mem_opcode.mem_inst_addr;
              state_r <= S_DONE;
            end else if (op7_any_s) begin
              pc_r    <= pc_r + ONE_A;
              state_r <= S_DONE;
            end else if (bus.pdp_mem_opcode.AND | bus.pdp_mem_opcode.TAD |
                         bus.pdp_mem_opcode.ISZ) begin
              stall_r  <= 1'b1;
              rd_req_r <= 1'b1;
              addr_r   <= bus.pdp_mem_opcode.mem_inst_addr;
              state_r  <= S_RD;
            end else begin
              stall_r  <= 1'b1;
              wr_req_r <= 1'b1;
              addr_r   <= bus.pdp_mem_opcode.mem_inst_addr;
              wdata_r  <= bus.pdp_mem_opcode.DCA ? ac_r : (pc_r + ONE_A);
              state_r  <= S_WR;
            end
          end
        end
        S_RD: begin
          if (bus.exec_mem_gnt) begin
            rd_req_r <= 1'b0;
            state_r  <= S_RDW;
          end
        end
        S_RDW: begin
          md_r    <= bus.exec_rdata;
          state_r <= S_EXE;
        end
        S_EXE: begin
          if (op_r[OP_AND]) begin
            ac_r    <= ac_r & md_r;
            pc_r    <= pc_r + ONE_A;
            stall_r <= 1'b0;
            state_r <= S_DONE;
          end else if (op_r[OP_TAD]) begin
            ac_r    <= sum_s[DATA_WIDTH-1:0];
            link_r  <= link_r ^ sum_s[DATA_WIDTH];
            pc_r    <= pc_r + ONE_A;
            stall_r <= 1'b0;
            state_r <= S_DONE;
          end else begin
            md_r     <= md_r + ONE_D;
            wr_req_r <= 1'b1;
            addr_r   <= ea_r;
            wdata_r  <= md_r + ONE_D;
            state_r  <= S_WR;
          end
        end
        // md_r already holds the incremented ISZ value here, so zero means skip
        S_WR: begin
          if (bus.exec_mem_gnt) begin
            wr_req_r <= 1'b0;
            stall_r  <= 1'b0;
            state_r  <= S_DONE;
            if (op_r[OP_DCA]) begin
              ac_r <= ZERO_D;
              pc_r <= pc_r + ONE_A;
            end else if (op_r[1]) begin
              pc_r <= ea_r + ONE_A;
            end else begin
              pc_r <= (md_r == ZERO_D) ? (pc_r + TWO_A) : (pc_r + ONE_A);
            end
          end
        end
        S_DONE: begin
          state_r <= S_CLR;
        end
        default: begin
          state_r  <= S_CLR;
          stall_r  <= 1'b0;
          rd_req_r <= 1'b0;
          wr_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall       = stall_r;
  assign bus.PC_value    = pc_r;
  assign bus.exec_rd_req = rd_req_r;
  assign bus.exec_wr_req = wr_req_r;
  assign bus.exec_addr   = addr_r;
  assign bus.exec_wdata  = wdata_r;
  assign ac              = ac_r;
  assign link            = link_r;
  assign illegal_op      = illegal_r;
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: memory/arbiter model with programmable
// grant denial and hand-computed expectations for every instruction.
module tb_exec_sequencer;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ac;
  logic        link;
  logic        illegal_op;

  exec_sequencer_if bus ();

  exec_sequencer #(.START_PC(12'o0200), .DATA_WIDTH(12)) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus),
    .ac(ac), .link(link), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] M_AND = 6'b100000;
  localparam logic [5:0] M_TAD = 6'b010000;
  localparam logic [5:0] M_ISZ = 6'b001000;
  localparam logic [5:0] M_DCA = 6'b000100;
  localparam logic [5:0] M_JMS = 6'b000010;
  localparam logic [5:0] M_JMP = 6'b000001;

  int errors = 0;
  int checks = 0;

  // Memory / arbiter model state (written only by the model process)
  logic [11:0] mem [0:4095];
  bit          mem_loaded = 1'b0;
  int          deny_target = 0;
  int          deny_done = 0;
  int          wr_cnt = 0;
  int          hold_samples = 0;
  int          hold_viol = 0;
  int          excl_viol = 0;
  logic        rd_seen, wr_seen;
  logic [11:0] addr_seen, wdata_seen;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Arbiter + memory: grant decided on negedge, applied at the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      if (!mem_loaded) begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'o0000;
        mem[12'o0077] = 12'o7777;
        mem[12'o0100] = 12'o0001;
        mem[12'o0101] = 12'o5555;
        mem[12'o0102] = 12'o3333;
        mem[12'o0104] = 12'o0123;
        mem[12'o0050] = 12'o7777;
        mem[12'o0051] = 12'o0005;
        mem[12'o0110] = 12'o4321;
        mem_loaded = 1'b1;
      end
      rd_seen = 1'b0;
      wr_seen = 1'b0;
      deny_done = 0;
      bus.exec_mem_gnt = 1'b0;
      bus.exec_rdata = 12'o0000;
    end else begin
      if (bus.exec_mem_gnt && rd_seen) bus.exec_rdata = mem[addr_seen];
      if (bus.exec_mem_gnt && wr_seen) begin
        mem[addr_seen] = wdata_seen;
        wr_cnt++;
      end
      if ((rd_seen || wr_seen) && !bus.exec_mem_gnt) begin
        hold_samples++;
        if ({bus.exec_rd_req, bus.exec_wr_req, bus.exec_addr, bus.exec_wdata} !==
            {rd_seen, wr_seen, addr_seen, wdata_seen}) hold_viol++;
      end else begin
        deny_done = 0;
      end
      if (bus.exec_rd_req && bus.exec_wr_req) excl_viol++;
      rd_seen    = bus.exec_rd_req;
      wr_seen    = bus.exec_wr_req;
      addr_seen  = bus.exec_addr;
      wdata_seen = bus.exec_wdata;
      if ((rd_seen || wr_seen) && deny_done < deny_target) begin
        bus.exec_mem_gnt = 1'b0;
        deny_done++;
      end else begin
        bus.exec_mem_gnt = rd_seen || wr_seen;
      end
    end
  end

  task automatic set_opcode(input logic [5:0] mbits, input logic [11:0] ea, input logic iac);
    bus.pdp_mem_opcode = {mbits, ea};
    bus.pdp_op7_opcode = '0;
    bus.pdp_op7_opcode.IAC = iac;
  endtask

  // Entered at posedge+1 in IDLE; returns accept-to-DONE latency and illegal_op pulse count
  task automatic run_op(input logic [5:0] mbits, input logic [11:0] ea, input logic iac,
                        input int deny, input int hold, output int lat, output int ill);
    bit done;
    int n;
    deny_target = deny;
    set_opcode(mbits, ea, iac);
    lat = 0; ill = 0; done = 1'b0; n = 0;
    while ((!done || n < hold) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == hold) set_opcode(6'b000000, 12'o0000, 1'b0);
      ill += int'(illegal_op);
      if (!done && !bus.stall) begin
        done = 1'b1;
        lat = n;
      end
    end
    check_value("op_completes", 32'(done), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      ill += int'(illegal_op);
    end
    deny_target = 0;
  endtask

  initial begin
    int lat, ill, w0, seen;
    set_opcode(6'b000000, 12'o0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_stall", 32'(bus.stall), 32'd0);
    check_value("rst_pc", 32'(bus.PC_value), 32'o0200);
    check_value("rst_ac", 32'(ac), 32'o0000);
    check_value("rst_link", 32'(link), 32'd0);
    check_value("rst_req", 32'({bus.exec_rd_req, bus.exec_wr_req}), 32'd0);
    check_value("rst_illegal", 32'(illegal_op), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    run_op(M_TAD, 12'o0077, 1'b0, 0, 1, lat, ill);
    check_value("tad_load_ac", 32'(ac), 32'o7777);
    check_value("tad_load_pc", 32'(bus.PC_value), 32'o0201);
    check_value("tad_load_lat", 32'(lat), 32'd4);
    run_op(M_JMP, 12'o0200, 1'b0, 0, 1, lat, ill);
    check_value("jmp_pc", 32'(bus.PC_value), 32'o0200);
    check_value("jmp_lat", 32'(lat), 32'd1);

    run_op(M_TAD, 12'o0100, 1'b0, 0, 1, lat, ill);
    check_value("tad_carry_ac", 32'(ac), 32'o0000);
    check_value("tad_carry_link", 32'(link), 32'd1);
    check_value("tad_carry_pc", 32'(bus.PC_value), 32'o0201);
    check_value("tad_carry_lat", 32'(lat), 32'd4);
    check_value("tad_carry_ill", 32'(ill), 32'd0);

    run_op(M_TAD, 12'o0101, 1'b0, 0, 1, lat, ill);
    check_value("tad_5555_ac", 32'(ac), 32'o5555);
    run_op(M_AND, 12'o0102, 1'b0, 0, 1, lat, ill);
    check_value("and_ac", 32'(ac), 32'o1111);
    check_value("and_link", 32'(link), 32'd1);
    check_value("and_pc", 32'(bus.PC_value), 32'o0203);
    check_value("and_lat", 32'(lat), 32'd4);
    run_op(M_TAD, 12'o0104, 1'b0, 0, 1, lat, ill);
    check_value("tad_1234_ac", 32'(ac), 32'o1234);

    w0 = wr_cnt;
    run_op(M_DCA, 12'o0105, 1'b0, 0, 1, lat, ill);
    check_value("dca_mem", 32'(mem[12'o0105]), 32'o1234);
    check_value("dca_ac", 32'(ac), 32'o0000);
    check_value("dca_pc", 32'(bus.PC_value), 32'o0205);
    check_value("dca_lat", 32'(lat), 32'd2);
    check_value("dca_wr_cnt", 32'(wr_cnt - w0), 32'd1);

    run_op(M_JMP, 12'o0200, 1'b0, 0, 1, lat, ill);
    run_op(M_JMS, 12'o0100, 1'b0, 0, 1, lat, ill);
    check_value("jms_mem", 32'(mem[12'o0100]), 32'o0201);
    check_value("jms_pc", 32'(bus.PC_value), 32'o0101);
    check_value("jms_lat", 32'(lat), 32'd2);

    run_op(M_JMP, 12'o0200, 1'b0, 0, 1, lat, ill);
    run_op(M_ISZ, 12'o0050, 1'b0, 0, 1, lat, ill);
    check_value("isz_wrap_mem", 32'(mem[12'o0050]), 32'o0000);
    check_value("isz_skip_pc", 32'(bus.PC_value), 32'o0202);
    check_value("isz_lat", 32'(lat), 32'd5);
    run_op(M_JMP, 12'o0200, 1'b0, 0, 1, lat, ill);
    run_op(M_ISZ, 12'o0051, 1'b0, 0, 1, lat, ill);
    check_value("isz_mem", 32'(mem[12'o0051]), 32'o0006);
    check_value("isz_noskip_pc", 32'(bus.PC_value), 32'o0201);

    run_op(M_TAD, 12'o0077, 1'b0, 5, 1, lat, ill);
    check_value("gnt_stall_lat", 32'(lat), 32'd9);
    check_value("gnt_stall_ac", 32'(ac), 32'o7777);
    check_value("gnt_stall_link", 32'(link), 32'd1);
    check_value("gnt_stall_pc", 32'(bus.PC_value), 32'o0202);
    check_value("gnt_hold_samples", 32'(hold_samples), 32'd5);
    check_value("gnt_hold_stable", 32'(hold_viol), 32'd0);

    run_op(M_AND | M_TAD, 12'o0100, 1'b0, 0, 1, lat, ill);
    check_value("illegal_pulse", 32'(ill), 32'd1);
    check_value("illegal_lat", 32'(lat), 32'd1);
    check_value("illegal_ac", 32'(ac), 32'o7777);
    check_value("illegal_pc", 32'(bus.PC_value), 32'o0203);
    run_op(M_TAD, 12'o0100, 1'b1, 0, 1, lat, ill);
    check_value("illegal_mix_pulse", 32'(ill), 32'd1);
    check_value("illegal_mix_pc", 32'(bus.PC_value), 32'o0204);

    run_op(6'b000000, 12'o0000, 1'b1, 0, 1, lat, ill);
    check_value("op7_pc", 32'(bus.PC_value), 32'o0205);
    check_value("op7_ill", 32'(ill), 32'd0);
    check_value("op7_lat", 32'(lat), 32'd1);
    run_op(6'b000000, 12'o0000, 1'b1, 0, 6, lat, ill);
    check_value("held_op7_pc", 32'(bus.PC_value), 32'o0206);
    run_op(M_TAD, 12'o0100, 1'b0, 0, 8, lat, ill);
    check_value("held_tad_ac", 32'(ac), 32'o0200);
    check_value("held_tad_link", 32'(link), 32'd0);
    check_value("held_tad_pc", 32'(bus.PC_value), 32'o0207);

    // Reset while in RDW
    set_opcode(M_TAD, 12'o0077, 1'b0);
    @(posedge clk); #1;
    set_opcode(6'b000000, 12'o0000, 1'b0);
    check_value("pre_rst_rd_req", 32'(bus.exec_rd_req), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_value("rdw_rst_stall", 32'(bus.stall), 32'd0);
    check_value("rdw_rst_pc", 32'(bus.PC_value), 32'o0200);
    check_value("rdw_rst_ac", 32'(ac), 32'o0000);
    check_value("rdw_rst_link", 32'(link), 32'd0);
    check_value("rdw_rst_req", 32'({bus.exec_rd_req, bus.exec_wr_req}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; seen += int'(bus.exec_wr_req) + int'(bus.exec_rd_req); end
    check_value("rdw_rst_quiet", 32'(seen), 32'd0);
    check_value("rdw_rst_ac_after", 32'(ac), 32'o0000);

    // Reset while a write is pending in WR
    run_op(M_JMP, 12'o0300, 1'b0, 0, 1, lat, ill);
    w0 = wr_cnt;
    deny_target = 3;
    set_opcode(M_DCA, 12'o0110, 1'b0);
    @(posedge clk); #1;
    set_opcode(6'b000000, 12'o0000, 1'b0);
    check_value("pre_rst_wr_req", 32'(bus.exec_wr_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("wr_rst_wr_req", 32'(bus.exec_wr_req), 32'd0);
    check_value("wr_rst_stall", 32'(bus.stall), 32'd0);
    check_value("wr_rst_pc", 32'(bus.PC_value), 32'o0200);
    deny_target = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; seen += int'(bus.exec_wr_req); end
    check_value("wr_rst_no_wr_req", 32'(seen), 32'd0);
    check_value("wr_rst_no_write", 32'(wr_cnt - w0), 32'd0);
    check_value("wr_rst_mem", 32'(mem[12'o0110]), 32'o4321);
    check_value("rd_wr_exclusive", 32'(excl_viol), 32'd0);
    check_value("req_stable_all", 32'(hold_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
